rv32_pmp_csr: RTL and testbench
===============================

Name: rv32_pmp_csr

Overview:
- Producer side of the PMP portion of the CSR shared bus.
- Holds the pmpcfg0-3 and pmpaddr0-15 machine CSRs, and serves CSR read/modify/write requests from the execution unit over a valid/ready handshake.
- Enforces lock and WARL rules on every write.
- Drives the pmpcfg/pmpaddr fields that the MPU consumes to compute imem/dmem access rights.

Parameters:
- XLEN, 32, register width; only 32 is supported.
- NB_PMP_REGION, 16, number of implemented PMP entries, 1..16.
- MAX_PMP_REGION, 16, number of entry slots laid out on the shared bus; fixed at 16.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- ctrl_valid  in  1  CSR request valid.
- ctrl_ready  out  1  block accepts a request; a request is accepted when ctrl_valid & ctrl_ready at the aclk edge.
- ctrl_addr  in  12  CSR address.
- ctrl_op  in  2  00 read-only, 01 RW (write), 10 RS (set), 11 RC (clear).
- ctrl_wdata  in  XLEN  write operand (rs1 or zimm).
- ctrl_rvalid  out  1  one-cycle response pulse.
- ctrl_rdata  out  XLEN  CSR value before the write; valid with ctrl_rvalid.
- ctrl_err  out  1  address is not a PMP CSR; valid with ctrl_rvalid.
- pmp_sb  out  4*XLEN+MAX_PMP_REGION*XLEN (640)  shared-bus slice.
  - Bits [i*8+:8]: pmpcfg entry i.
  - Bits [4*XLEN+i*XLEN+:XLEN]: pmpaddr i.
  - Concatenated at offset 0 of the CSR shared bus.

Behaviour:
- Clock and reset: one clock, aclk. srst is synchronous and active-high.
- Reset values:
  - All cfg and addr registers 0, so pmp_sb = 0.
  - ctrl_rvalid = 0, ctrl_err = 0, ctrl_rdata = 0.
  - ctrl_ready = 0 while srst is high; 1 in the first cycle after srst is released.
- Address map:
  - 0x3A0-0x3A3: pmpcfg0-3; byte k of pmpcfgN is entry 4N+k.
  - 0x3B0-0x3BF: pmpaddr0-15.
  - Any other address: ctrl_err = 1, ctrl_rdata = 0, no state change.
- FSM IDLE -> RMW -> RESP -> IDLE.
  - IDLE: ctrl_ready = 1. On accept (edge N), latch addr, op and wdata; go to RMW.
  - RMW (cycle N+1): ctrl_ready = 0. Register the old value. Compute the new value:
    - RW: wdata.
    - RS: old | wdata.
    - RC: old & ~wdata.
  - RESP (cycle N+2): the register update is visible on pmp_sb from this cycle. ctrl_rvalid = 1, ctrl_rdata = old value, ctrl_ready = 0.
  - Back to IDLE: ctrl_ready = 1 at N+3. Next accept is possible at edge N+3, so throughput is 1 request per 3 cycles.
- Write suppression:
  - op = 00 never writes.
  - RS or RC with wdata = 0 does not write (no side effects).
- pmpcfg write, applied per byte/entry i independently:
  - The byte is ignored if the pre-write L bit (bit 7) of entry i is set.
  - WARL: bits 6:5 are stored and read as 0.
  - If the new R = 0 and W = 1, W is stored as 0.
  - A values OFF, TOR, NA4 and NAPOT are all legal.
- pmpaddr i write is ignored if either holds:
  - pre-write cfg[i].L = 1;
  - i+1 < NB_PMP_REGION and pre-write cfg[i+1].L = 1 and cfg[i+1].A = TOR.
- Lock checks always use register values sampled in RMW. A write that sets L takes effect for subsequent requests only.
- L is sticky until srst.
- Entries i >= NB_PMP_REGION: read 0, writes ignored, pmp_sb slots are 0.
- Read data reflects stored (post-WARL) values, never raw wdata.
- srst mid-transaction (during RMW or RESP):
  - The transaction is dropped: no rvalid, no write.
  - All state returns to reset values on that edge.
- ctrl_valid is ignored outside IDLE. The requester holds its request until ctrl_ready.

Test Plan:
- Reset then write pmpaddr0 (0x3B0, RW, 0x0000_0400), then write pmpcfg0 (0x3A0, RW, 0x0000_000F):
  - rvalid 2 cycles after each accept, rdata = 0.
  - pmp_sb[7:0] = 0x0F; pmp_sb[159:128] = 0x400.
  - Reading 0x3A0 returns 0x0000_000F.
- WARL: RW 0x3A0 with 0x0000_6A62 (entry0 = 0x62, entry1 = 0x6A):
  - Entry0 stored 0x00: bits 6:5 dropped; R=0/W=1 with W cleared.
  - Entry1 stored 0x08: bits 6:5 dropped; R=0/W=1 with W cleared.
  - Read back = 0x0000_0800.
- Lock: cfg entry 2 = 0x8B (L, TOR, W, R):
  - RW pmpcfg0 0xFFFF_FFFF leaves byte2 = 0x8B.
  - RW pmpaddr2 and RW pmpaddr1 (TOR predecessor) leave both unchanged.
  - pmpaddr3 is still writable.
  - srst clears the lock.
- RS/RC: pmpaddr5 = 0xF0; RS 0x0F -> 0xFF; RC 0xF0 -> 0x0F, with rdata = 0xFF.
  - RS with wdata 0 on locked entry 2: rdata correct, no write.
- Illegal address 0x3C0 and pmpaddr15 with NB_PMP_REGION = 8:
  - 0x3C0: ctrl_err = 1, rdata = 0.
  - pmpaddr15: err = 0, reads 0, write ignored, slot 15 on pmp_sb stays 0.
- Back-to-back requests with ctrl_valid held high:
  - Accepts at edges N and N+3; ready low in between.
- srst asserted in RMW: no rvalid, no write.

Source files
------------

// File: rtl/rv32_pmp_csr_if.sv
// ----------------------------------------------------------------------------
// rv32_pmp_csr_if
//   CSR request/response channel between the execution unit (master) and the
//   PMP CSR block (slave).
//   ctrl_valid / ctrl_ready : request handshake, accepted when both are high
//                             at the clock edge
//   ctrl_addr               : 12-bit CSR address
//   ctrl_op                 : 00 read, 01 write, 10 set bits, 11 clear bits
//   ctrl_wdata              : write operand
//   ctrl_rvalid             : one-cycle response strobe
//   ctrl_rdata              : CSR value before the write (valid with rvalid)
//   ctrl_err                : address is not a PMP CSR (valid with rvalid)
// ----------------------------------------------------------------------------
interface rv32_pmp_csr_if #(
   parameter int unsigned XLEN = 32
);
   logic            ctrl_valid;
   logic            ctrl_ready;
   logic [11:0]     ctrl_addr;
   logic [1:0]      ctrl_op;
   logic [XLEN-1:0] ctrl_wdata;
   logic            ctrl_rvalid;
   logic [XLEN-1:0] ctrl_rdata;
   logic            ctrl_err;

   modport master (
      output ctrl_valid, ctrl_addr, ctrl_op, ctrl_wdata,
      input  ctrl_ready, ctrl_rvalid, ctrl_rdata, ctrl_err
   );

   modport slave (
      input  ctrl_valid, ctrl_addr, ctrl_op, ctrl_wdata,
      output ctrl_ready, ctrl_rvalid, ctrl_rdata, ctrl_err
   );
endinterface

// File: rtl/rv32_pmp_csr.sv
// ----------------------------------------------------------------------------
// rv32_pmp_csr
//   Holds pmpcfg0-3 and pmpaddr0-15, serves CSR read/set/clear/write requests
//   with lock and WARL rules, and exports all entries on the shared bus.
//   Ports:
//     aclk   : clock
//     srst   : synchronous active-high reset
//     ctrl   : CSR request/response channel (slave side)
//     pmp_sb : bits [i*8+:8] = pmpcfg entry i,
//              bits [4*XLEN+i*XLEN+:XLEN] = pmpaddr i
//   Only XLEN = 32 is supported. Entries >= NB_PMP_REGION read as zero and
//   ignore writes.
// ----------------------------------------------------------------------------
module rv32_pmp_csr #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned NB_PMP_REGION  = 16,
   parameter int unsigned MAX_PMP_REGION = 16
) (
   input  logic                                      aclk,
   input  logic                                      srst,
   rv32_pmp_csr_if.slave                             ctrl,
   output logic [4*XLEN+MAX_PMP_REGION*XLEN-1:0]     pmp_sb
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RMW  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } csr_op_t;

   state_t          state_q;
   logic [11:0]     req_addr_q;
   csr_op_t         req_op_q;
   logic [XLEN-1:0] req_wdata_q;
   logic            rvalid_q;
   logic            err_q;
   logic [XLEN-1:0] rdata_q;

   logic [7:0]      cfg_q     [MAX_PMP_REGION];
   logic [XLEN-1:0] pmpaddr_q [MAX_PMP_REGION];
   logic [7:0]      cfg_d     [MAX_PMP_REGION];
   logic [XLEN-1:0] pmpaddr_d [MAX_PMP_REGION];

   logic            is_cfg;
   logic            is_addr;
   logic            wr_en;
   logic [XLEN-1:0] old_val;
   logic [XLEN-1:0] new_val;

   // Ready is gated by srst so the block never advertises acceptance while
   // reset is held, yet is ready in the very first cycle after release.
   assign ctrl.ctrl_ready  = (state_q == ST_IDLE) && !srst;
   assign ctrl.ctrl_rvalid = rvalid_q && !srst;
   assign ctrl.ctrl_rdata  = rdata_q;
   assign ctrl.ctrl_err    = err_q;

   // Decode of the latched request and old-value read.
   always_comb begin
      is_cfg  = (req_addr_q[11:2] == 10'h0E8);   // 0x3A0..0x3A3
      is_addr = (req_addr_q[11:4] == 8'h3B);     // 0x3B0..0x3BF
      old_val = '0;
      if (is_cfg) begin
         for (int unsigned k = 0; k < 4; k++) begin
            old_val[k*8 +: 8] = cfg_q[{req_addr_q[1:0], 2'(k)}];
         end
      end else if (is_addr) begin
         old_val = pmpaddr_q[req_addr_q[3:0]];
      end

      // Set/clear with a zero operand has no side effects at all.
      wr_en = (is_cfg || is_addr) && (req_op_q != OP_READ) &&
              ((req_op_q == OP_RW) || (req_wdata_q != '0));

      case (req_op_q)
         OP_RS:   new_val = old_val | req_wdata_q;
         OP_RC:   new_val = old_val & ~req_wdata_q;
         default: new_val = req_wdata_q;
      endcase
   end

   // Next register contents; every lock decision uses the pre-write values.
   always_comb begin : next_state
      int unsigned idx;
      int unsigned nxt;
      logic [7:0]  b;
      logic        tor_lock;
      idx      = 0;
      nxt      = 0;
      b        = '0;
      tor_lock = 1'b0;
      cfg_d     = cfg_q;
      pmpaddr_d = pmpaddr_q;

      if (wr_en && is_cfg) begin
         for (int unsigned k = 0; k < 4; k++) begin
            idx = 4 * 32'(req_addr_q[1:0]) + k;
            if ((idx < NB_PMP_REGION) && !cfg_q[idx[3:0]][7]) begin
               b      = new_val[k*8 +: 8];
               b[6:5] = 2'b00;
               if (!b[0]) begin
                  b[1] = 1'b0;       // W without R is not a legal combination
               end
               cfg_d[idx[3:0]] = b;
            end
         end
      end

      if (wr_en && is_addr) begin
         idx = 32'(req_addr_q[3:0]);
         nxt = idx + 1;
         // A locked TOR entry above also freezes this address as its base.
         tor_lock = (nxt < NB_PMP_REGION) && cfg_q[nxt[3:0]][7] &&
                    (cfg_q[nxt[3:0]][4:3] == 2'b01);
         if ((idx < NB_PMP_REGION) && !cfg_q[idx[3:0]][7] && !tor_lock) begin
            pmpaddr_d[idx[3:0]] = new_val;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         req_addr_q  <= '0;
         req_op_q    <= OP_READ;
         req_wdata_q <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         for (int unsigned i = 0; i < MAX_PMP_REGION; i++) begin
            cfg_q[i]     <= '0;
            pmpaddr_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               rvalid_q <= 1'b0;
               if (ctrl.ctrl_valid) begin
                  req_addr_q  <= ctrl.ctrl_addr;
                  req_op_q    <= csr_op_t'(ctrl.ctrl_op);
                  req_wdata_q <= ctrl.ctrl_wdata;
                  state_q     <= ST_RMW;
               end
            end
            ST_RMW: begin
               rdata_q   <= old_val;
               err_q     <= !(is_cfg || is_addr);
               rvalid_q  <= 1'b1;
               cfg_q     <= cfg_d;
               pmpaddr_q <= pmpaddr_d;
               state_q   <= ST_RESP;
            end
            ST_RESP: begin
               rvalid_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               rvalid_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      pmp_sb = '0;
      for (int unsigned i = 0; i < MAX_PMP_REGION; i++) begin
         pmp_sb[i*8 +: 8]                 = cfg_q[i];
         pmp_sb[4*XLEN + i*XLEN +: XLEN]  = pmpaddr_q[i];
      end
   end

endmodule

// File: tb/tb_rv32_pmp_csr.sv
module tb_rv32_pmp_csr;

   logic clk  = 1'b0;
   logic srst = 1'b1;
   always #5 clk = ~clk;

   rv32_pmp_csr_if #(.XLEN(32)) if0 ();
   rv32_pmp_csr_if #(.XLEN(32)) if1 ();
   logic [639:0] sb0;
   logic [639:0] sb1;

   rv32_pmp_csr #(.XLEN(32), .NB_PMP_REGION(16), .MAX_PMP_REGION(16)) dut0 (
      .aclk(clk), .srst(srst), .ctrl(if0.slave), .pmp_sb(sb0));
   rv32_pmp_csr #(.XLEN(32), .NB_PMP_REGION(8), .MAX_PMP_REGION(16)) dut1 (
      .aclk(clk), .srst(srst), .ctrl(if1.slave), .pmp_sb(sb1));

   typedef struct {
      logic [31:0]  rdata;
      logic         err;
      int unsigned  acc;
      logic [639:0] bus;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Reference model: plain arrays of entries, one set per DUT.
   logic [7:0]  mcfg  [2][16];
   logic [31:0] maddr [2][16];
   int          nb    [2];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          errors = 0;
   int          checks = 0;
   int unsigned last_acc = 0;

   task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input int d, input logic [11:0] a, output logic err);
      logic [31:0] v;
      int n;
      v = '0;
      err = 1'b0;
      if (a >= 12'h3A0 && a <= 12'h3A3) begin
         n = int'(a - 12'h3A0);
         for (int k = 0; k < 4; k++) v[k*8 +: 8] = mcfg[d][n*4 + k];
      end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
         v = maddr[d][int'(a - 12'h3B0)];
      end else begin
         err = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [639:0] m_bus(input int d);
      logic [639:0] b;
      b = '0;
      for (int e = 0; e < 16; e++) begin
         b[e*8 +: 8]         = mcfg[d][e];
         b[128 + e*32 +: 32] = maddr[d][e];
      end
      return b;
   endfunction

   task automatic m_write(input int d, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
      logic        err;
      logic [31:0] old;
      logic [31:0] nv;
      logic [7:0]  b;
      int          n;
      int          e;
      old = m_read(d, a, err);
      if (err || op == 2'b00 || (op != 2'b01 && wd == 32'd0)) return;
      if (op == 2'b01)      nv = wd;
      else if (op == 2'b10) nv = old | wd;
      else                  nv = old & ~wd;
      if (a < 12'h3B0) begin
         n = int'(a - 12'h3A0);
         for (int k = 0; k < 4; k++) begin
            e = n*4 + k;
            if (e < nb[d] && !mcfg[d][e][7]) begin
               b = nv[k*8 +: 8] & 8'h9F;
               if (b[1:0] == 2'b10) b[1] = 1'b0;
               mcfg[d][e] = b;
            end
         end
      end else begin
         e = int'(a - 12'h3B0);
         if (e < nb[d] && !mcfg[d][e][7] &&
             !(e + 1 < nb[d] && mcfg[d][e+1][7] && mcfg[d][e+1][4:3] == 2'b01))
            maddr[d][e] = nv;
      end
   endtask

   task automatic m_reset();
      for (int d = 0; d < 2; d++)
         for (int e = 0; e < 16; e++) begin
            mcfg[d][e]  = '0;
            maddr[d][e] = '0;
         end
   endtask

   task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
      if0.ctrl_valid = v; if0.ctrl_addr = a; if0.ctrl_op = op; if0.ctrl_wdata = wd;
      if1.ctrl_valid = v; if1.ctrl_addr = a; if1.ctrl_op = op; if1.ctrl_wdata = wd;
   endtask

   task automatic drop_valid();
      if0.ctrl_valid = 1'b0;
      if1.ctrl_valid = 1'b0;
   endtask

   task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         input bit expect_resp, input bit hold);
      int   n;
      exp_t x;
      logic err;
      @(negedge clk);
      drive(1'b1, a, op, wd);
      n = 0;
      while (!(if0.ctrl_ready && if1.ctrl_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout addr=%0h actual=not_ready required=ready", a);
         drop_valid();
         return;
      end
      @(posedge clk);
      last_acc = cyc;
      if (expect_resp) begin
         for (int d = 0; d < 2; d++) begin
            x.rdata = m_read(d, a, err);
            x.err   = err;
            x.acc   = cyc;
            m_write(d, a, op, wd);
            x.bus   = m_bus(d);
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
         end
      end
      if (!hold) begin
         @(negedge clk);
         drop_valid();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      srst = 1'b1;
      drop_valid();
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready0", if0.ctrl_ready, 0);
      chk("rst_ready1", if1.ctrl_ready, 0);
      chk("rst_rvalid0", if0.ctrl_rvalid, 0);
      chk("rst_rdata0", if0.ctrl_rdata, 0);
      chk("rst_err0", if0.ctrl_err, 0);
      chk("rst_bus0", sb0, 0);
      chk("rst_bus1", sb1, 0);
      m_reset();
      q0.delete();
      q1.delete();
      srst = 1'b0;
      #1;
      chk("rel_ready0", if0.ctrl_ready, 1);
      chk("rel_ready1", if1.ctrl_ready, 1);
   endtask

   task automatic mon(input int d, input logic rv, input logic [31:0] rd, input logic er,
                      input logic [639:0] bus);
      exp_t x;
      int   sz;
      if (!rv) return;
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL spurious_rvalid dut%0d actual=1 required=0", d);
         return;
      end
      if (d == 0) x = q0.pop_front();
      else        x = q1.pop_front();
      chk($sformatf("rdata_dut%0d", d), rd, x.rdata);
      chk($sformatf("err_dut%0d", d), er, x.err);
      chk($sformatf("latency_dut%0d", d), cyc - x.acc, 2);
      chk($sformatf("bus_dut%0d", d), bus, x.bus);
   endtask

   always @(negedge clk) begin
      mon(0, if0.ctrl_rvalid, if0.ctrl_rdata, if0.ctrl_err, sb0);
      mon(1, if1.ctrl_rvalid, if1.ctrl_rdata, if1.ctrl_err, sb1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a0;
      logic [11:0] ra;
      logic [1:0]  rop;
      logic [31:0] rwd;
      int unsigned sel;
      nb[0] = 16;
      nb[1] = 8;
      m_reset();
      drive(1'b0, 12'h000, 2'b00, 32'd0);

      // Basic write/read
      do_reset();
      do_req(12'h3B0, 2'b01, 32'h0000_0400, 1, 0);
      do_req(12'h3A0, 2'b01, 32'h0000_000F, 1, 0);
      do_req(12'h3A0, 2'b00, 32'h0000_0000, 1, 0);
      drain();
      chk("basic_cfg0", sb0[7:0], 8'h0F);
      chk("basic_addr0", sb0[159:128], 32'h400);

      // WARL on pmpcfg bytes
      do_req(12'h3A0, 2'b01, 32'h0000_6A62, 1, 0);
      do_req(12'h3A0, 2'b00, 32'h0000_0000, 1, 0);
      drain();
      chk("warl_cfg0", sb0[15:0], 16'h0800);

      // Lock on entry 2 (L, TOR, W, R) and its TOR predecessor
      do_reset();
      do_req(12'h3B1, 2'b01, 32'h0000_0111, 1, 0);
      do_req(12'h3B2, 2'b01, 32'h0000_0222, 1, 0);
      do_req(12'h3A0, 2'b01, 32'h008B_0000, 1, 0);
      do_req(12'h3B2, 2'b01, 32'h0000_AAAA, 1, 0);
      do_req(12'h3B1, 2'b01, 32'h0000_BBBB, 1, 0);
      do_req(12'h3B3, 2'b01, 32'h0000_0333, 1, 0);
      do_req(12'h3A0, 2'b01, 32'hFFFF_FFFF, 1, 0);
      do_req(12'h3A0, 2'b10, 32'h0000_0000, 1, 0);
      drain();
      chk("lock_byte2", sb0[23:16], 8'h8B);
      chk("lock_addr1", sb0[128+1*32 +: 32], 32'h111);
      chk("lock_addr2", sb0[128+2*32 +: 32], 32'h222);
      chk("lock_addr3", sb0[128+3*32 +: 32], 32'h333);

      // Set / clear
      do_req(12'h3B5, 2'b01, 32'h0000_00F0, 1, 0);
      do_req(12'h3B5, 2'b10, 32'h0000_000F, 1, 0);
      do_req(12'h3B5, 2'b11, 32'h0000_00F0, 1, 0);
      drain();
      chk("rsrc_addr5", sb0[128+5*32 +: 32], 32'h0F);

      // Reset releases the lock
      do_reset();
      do_req(12'h3B2, 2'b01, 32'h0000_1234, 1, 0);
      drain();
      chk("unlock_addr2", sb0[128+2*32 +: 32], 32'h1234);

      // Illegal address and unimplemented entries on the 8-entry instance
      do_req(12'h3C0, 2'b01, 32'h0000_1234, 1, 0);
      do_req(12'h3C0, 2'b00, 32'h0000_0000, 1, 0);
      do_req(12'h3BF, 2'b01, 32'h0000_DEAD, 1, 0);
      do_req(12'h3BF, 2'b00, 32'h0000_0000, 1, 0);
      do_req(12'h3A2, 2'b01, 32'h0F0F_0F0F, 1, 0);
      do_req(12'h3A2, 2'b00, 32'h0000_0000, 1, 0);
      drain();
      chk("nb8_slot15", sb1[128+15*32 +: 32], 32'h0);
      chk("nb16_slot15", sb0[128+15*32 +: 32], 32'hDEAD);

      // Back-to-back with valid held high
      do_req(12'h3B4, 2'b01, 32'h0000_0001, 1, 1);
      a0 = last_acc;
      do_req(12'h3B4, 2'b10, 32'h0000_0002, 1, 0);
      chk("b2b_spacing", last_acc - a0, 3);
      drain();

      // srst during RMW drops the transaction
      do_req(12'h3B6, 2'b01, 32'h0000_0055, 0, 0);
      srst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rmw_rst_rvalid", if0.ctrl_rvalid, 0);
      chk("rmw_rst_addr6", sb0[128+6*32 +: 32], 32'h0);
      do_reset();

      // Randomised traffic
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      ra = 12'h3A0 + 12'($urandom_range(0, 3));
         else if (sel < 8) ra = 12'h3B0 + 12'($urandom_range(0, 15));
         else              ra = 12'($urandom_range(0, 4095));
         rop = 2'($urandom_range(0, 3));
         rwd = $urandom();
         if ($urandom_range(0, 3) != 0) rwd = rwd & 32'h7F7F_7F7F;
         if ($urandom_range(0, 4) == 0) rwd = 32'd0;
         do_req(ra, rop, rwd, 1, bit'($urandom_range(0, 1)));
      end
      @(negedge clk);
      drop_valid();
      drain();
      chk("final_bus0", sb0, m_bus(0));
      chk("final_bus1", sb1, m_bus(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
